// File: rtl/mem_resp.sv
// Memory-side bus responder: synchronises the active-low R/W command, decodes NB
// segment and address, runs a local word store and answers OK/EN with a 4-phase handshake.
module mem_resp #(
  parameter int SEG           = 0,
  parameter int ADDR_BITS     = 12,
  parameter int ACCESS_CYCLES = 2,
  parameter int RO_WORDS      = 0
) (
  input  logic        clk_sys,
  input  logic        clm_,
  input  logic        r_,
  input  logic        w_,
  input  logic [3:0]  nb_,
  input  logic [15:0] ad_,
  input  logic [15:0] dt_in_,
  output logic [15:0] dt_out_,
  output logic        ok_,
  output logic        en_,
  output logic        busy
);

  localparam int           CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [3:0]   SEG_V    = 4'(SEG);
  localparam logic [31:0]  RO_LIM   = 32'(RO_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, REPLY} state_t;

  state_t                 state, state_nx;
  logic [1:0]             r_sync, w_sync;
  logic                   rs, ws;
  logic                   op_write_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [15:0]            data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [15:0]            ad_n;
  logic                   match, cmd_act, last, ro_hit;
  logic                   accept, finish, release_reply, mem_we;
  logic [15:0]            mem [2**ADDR_BITS];

  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge clm_) begin
    if (!clm_) begin
      r_sync <= 2'b00;
      w_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], ~r_};
      w_sync <= {w_sync[0], ~w_};
    end
  end

  assign rs      = r_sync[1];
  assign ws      = w_sync[1];
  assign ad_n    = ~ad_;
  assign match   = ((~nb_) == SEG_V) && ((ad_n >> ADDR_BITS) == 16'd0);
  assign cmd_act = op_write_q ? ws : rs;
  assign last    = (cnt_q == '0);
  assign ro_hit  = (32'(addr_q) < RO_LIM);
  assign busy    = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    finish        = 1'b0;
    release_reply = 1'b0;
    mem_we        = 1'b0;
    case (state)
      IDLE: begin
        if ((rs ^ ws) && match) begin
          state_nx = ACCESS;
          accept   = 1'b1;
        end
      end
      ACCESS: begin
        if (!cmd_act) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = REPLY;
          finish   = 1'b1;
          mem_we   = op_write_q && !ro_hit;
        end
      end
      REPLY: begin
        if (!cmd_act) begin
          state_nx      = IDLE;
          release_reply = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge clm_) begin
    if (!clm_) begin
      state      <= IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      ok_        <= 1'b1;
      en_        <= 1'b1;
      dt_out_    <= 16'hFFFF;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_write_q <= ws;
        addr_q     <= ad_n[ADDR_BITS-1:0];
        data_q     <= ~dt_in_;
        cnt_q      <= CNT_LOAD;
      end else if (state == ACCESS && !last) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (finish) begin
        if (!op_write_q) begin
          ok_     <= 1'b0;
          dt_out_ <= ~mem[addr_q];
        end else if (ro_hit) begin
          en_ <= 1'b0;
        end else begin
          ok_ <= 1'b0;
        end
      end
      if (release_reply) begin
        ok_     <= 1'b1;
        en_     <= 1'b1;
        dt_out_ <= 16'hFFFF;
      end
    end
  end

  // NOTE: the store has no reset; its contents must survive master clear.
  always_ff @(posedge clk_sys) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: scoreboarded bus transactions, latency,
// handshake release, unmatched/ambiguous commands, read-only refusal, abort and reset.
module tb_mem_resp;

  localparam int AC = 2;

  logic        clk_sys = 1'b0;
  logic        clm_;
  logic        r_, w_;
  logic [3:0]  nb_;
  logic [15:0] ad_, dt_in_, dt_out_;
  logic        ok_, en_, busy;

  mem_resp #(.SEG(3), .ADDR_BITS(12), .ACCESS_CYCLES(AC), .RO_WORDS(16)) dut (
    .clk_sys(clk_sys), .clm_(clm_), .r_(r_), .w_(w_), .nb_(nb_), .ad_(ad_),
    .dt_in_(dt_in_), .dt_out_(dt_out_), .ok_(ok_), .en_(en_), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       tag;
    logic        ok;
    logic        en;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic ok, input logic en, input logic [15:0] data);
    exp_t e;
    e.tag = tag; e.ok = ok; e.en = en; e.data = data;
    sb.push_back(e);
  endtask

  task automatic issue(input bit wr, input logic [3:0] nb, input logic [15:0] addr,
                       input logic [15:0] data);
    @(negedge clk_sys);
    nb_    = ~nb;
    ad_    = ~addr;
    dt_in_ = ~data;
    if (wr) w_ = 1'b0;
    else    r_ = 1'b0;
  endtask

  // Edge 0 is the first posedge after the command goes low; reply expected after edge 2+AC.
  task automatic expect_reply();
    exp_t e;
    int   lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_sys); #1;
      if (!ok_ || !en_) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    check({e.tag, " latency"}, 32'(lat), 32'(2 + AC));
    check({e.tag, " ok_"}, 32'(ok_), 32'(e.ok));
    check({e.tag, " en_"}, 32'(en_), 32'(e.en));
    check({e.tag, " dt_out_"}, 32'(dt_out_), 32'(e.data));
    check({e.tag, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic release_cmd(input string tag);
    int lat = -1;
    @(negedge clk_sys);
    r_ = 1'b1;
    w_ = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_sys); #1;
      if (ok_ && en_) begin
        lat = k;
        break;
      end
    end
    check({tag, " release latency"}, 32'(lat), 32'd2);
    check({tag, " release dt_out_"}, 32'(dt_out_), 32'hFFFF);
    check({tag, " release busy"}, 32'(busy), 32'd0);
  endtask

  task automatic expect_silent(input string tag, input int cycles, input bit chk_busy);
    bit quiet = 1'b1;
    bit bsy   = 1'b0;
    repeat (cycles) begin
      @(posedge clk_sys); #1;
      if (!ok_ || !en_ || dt_out_ != 16'hFFFF) quiet = 1'b0;
      if (busy) bsy = 1'b1;
    end
    check({tag, " no reply"}, 32'(quiet), 32'd1);
    if (chk_busy) check({tag, " busy"}, 32'(bsy), 32'd0);
  endtask

  task automatic drop_cmd();
    @(negedge clk_sys);
    r_ = 1'b1;
    w_ = 1'b1;
    repeat (4) @(posedge clk_sys);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit held;
    clm_ = 1'b0; r_ = 1'b1; w_ = 1'b1;
    nb_ = 4'hF; ad_ = 16'hFFFF; dt_in_ = 16'hFFFF;

    repeat (3) @(posedge clk_sys);
    #1;
    check("reset ok_", 32'(ok_), 32'd1);
    check("reset en_", 32'(en_), 32'd1);
    check("reset dt_out_", 32'(dt_out_), 32'hFFFF);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    clm_ = 1'b1;
    repeat (2) @(posedge clk_sys);

    // Basic write/read round trips, including the top in-range address.
    push("wr 0123", 1'b0, 1'b1, 16'hFFFF);
    issue(1'b1, 4'd3, 16'h0123, 16'hBEEF); expect_reply(); release_cmd("wr 0123");
    push("rd 0123", 1'b0, 1'b1, ~16'hBEEF);
    issue(1'b0, 4'd3, 16'h0123, 16'h0000); expect_reply(); release_cmd("rd 0123");
    push("wr 0200", 1'b0, 1'b1, 16'hFFFF);
    issue(1'b1, 4'd3, 16'h0200, 16'h1357); expect_reply(); release_cmd("wr 0200");
    push("wr 0FFF", 1'b0, 1'b1, 16'hFFFF);
    issue(1'b1, 4'd3, 16'h0FFF, 16'hA5C3); expect_reply(); release_cmd("wr 0FFF");
    push("rd 0FFF", 1'b0, 1'b1, ~16'hA5C3);
    issue(1'b0, 4'd3, 16'h0FFF, 16'h0000); expect_reply(); release_cmd("rd 0FFF");

    // Unmatched segment and out-of-range address stay silent.
    issue(1'b0, 4'd5, 16'h0123, 16'h0000); expect_silent("nb 5", 50, 1'b1); drop_cmd();
    issue(1'b0, 4'd3, 16'h1000, 16'h0000); expect_silent("ad 1000", 50, 1'b1); drop_cmd();

    // Read-only region: the store is never cleared, so the baseline comes from a read.
    push("rd 0005 base", 1'b0, 1'b1, 16'h0000);
    issue(1'b0, 4'd3, 16'h0005, 16'h0000);
    begin
      int lat = -1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk_sys); #1;
        if (!ok_ || !en_) begin lat = k; break; end
      end
      void'(sb.pop_front());
      check("rd 0005 base latency", 32'(lat), 32'(2 + AC));
      check("rd 0005 base ok_", 32'(ok_), 32'd0);
      base = ~dt_out_;
    end
    release_cmd("rd 0005 base");
    push("wr 0005 ro", 1'b1, 1'b0, 16'hFFFF);
    issue(1'b1, 4'd3, 16'h0005, 16'h1234); expect_reply(); release_cmd("wr 0005 ro");
    push("rd 0005 after", 1'b0, 1'b1, ~base);
    issue(1'b0, 4'd3, 16'h0005, 16'h0000); expect_reply(); release_cmd("rd 0005 after");
    push("wr 000F ro", 1'b1, 1'b0, 16'hFFFF);
    issue(1'b1, 4'd3, 16'h000F, 16'h7777); expect_reply(); release_cmd("wr 000F ro");
    push("wr 0010", 1'b0, 1'b1, 16'hFFFF);
    issue(1'b1, 4'd3, 16'h0010, 16'h0F0F); expect_reply(); release_cmd("wr 0010");
    push("rd 0010", 1'b0, 1'b1, ~16'h0F0F);
    issue(1'b0, 4'd3, 16'h0010, 16'h0000); expect_reply(); release_cmd("rd 0010");

    // Read and write together: ambiguous, ignored.
    @(negedge clk_sys);
    nb_ = ~4'd3; ad_ = ~16'h0123; dt_in_ = ~16'h4444;
    r_ = 1'b0; w_ = 1'b0;
    expect_silent("r+w", 50, 1'b1);
    drop_cmd();

    // Write aborted in ACCESS: w_ drops after edge 1, latched at edge 2, aborted at edge 4.
    issue(1'b1, 4'd3, 16'h0123, 16'h0000);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    w_ = 1'b1;
    @(posedge clk_sys); #1;
    check("abort accepted busy", 32'(busy), 32'd1);
    expect_silent("abort", 30, 1'b0);
    check("abort idle busy", 32'(busy), 32'd0);
    push("rd 0123 after abort", 1'b0, 1'b1, ~16'hBEEF);
    issue(1'b0, 4'd3, 16'h0123, 16'h0000); expect_reply(); release_cmd("rd after abort");

    // Long hold, then back-to-back read.
    push("rd 0200 hold", 1'b0, 1'b1, ~16'h1357);
    issue(1'b0, 4'd3, 16'h0200, 16'h0000); expect_reply();
    held = 1'b1;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (ok_ !== 1'b0 || dt_out_ !== ~16'h1357) held = 1'b0;
    end
    check("hold reply stable", 32'(held), 32'd1);
    release_cmd("rd 0200 hold");
    push("rd 0123 b2b", 1'b0, 1'b1, ~16'hBEEF);
    issue(1'b0, 4'd3, 16'h0123, 16'h0000); expect_reply(); release_cmd("rd 0123 b2b");

    // Master clear mid-reply acts without a clock edge; store survives.
    push("rd 0FFF pre-clr", 1'b0, 1'b1, ~16'hA5C3);
    issue(1'b0, 4'd3, 16'h0FFF, 16'h0000); expect_reply();
    #2;
    clm_ = 1'b0;
    #1;
    check("clr ok_", 32'(ok_), 32'd1);
    check("clr en_", 32'(en_), 32'd1);
    check("clr dt_out_", 32'(dt_out_), 32'hFFFF);
    check("clr busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    r_ = 1'b1;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    clm_ = 1'b1;
    repeat (2) @(posedge clk_sys);
    push("rd 0FFF post-clr", 1'b0, 1'b1, ~16'hA5C3);
    issue(1'b0, 4'd3, 16'h0FFF, 16'h0000); expect_reply(); release_cmd("rd 0FFF post-clr");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
